qspi_psram_resp: RTL

//  Synthesizable QSPI target that emulates a quad-mode PSRAM; the responder end of the QSPI master's sck/ce_n/sio link.

---
 rtl/qspi_resp_pkg.sv | 19 +
 rtl/qspi_sync_edge.sv | 27 ++
 rtl/qspi_psram_resp.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_resp_pkg.sv
// Shared constants for the quad-SPI PSRAM responder: command opcodes,
// address framing and the transaction state encoding.
package qspi_resp_pkg;

    localparam logic [7:0] CMD_QREAD    = 8'hEB;
    localparam logic [7:0] CMD_QWRITE   = 8'h38;
    localparam int         ADDR_NIBBLES = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RDATA  = 3'd4,
        ST_WDATA  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

endpackage

// File: rtl/qspi_sync_edge.sv
// Two-flop synchroniser for an asynchronous control input, with single-clk
// rise/fall pulses derived from the synchronised history.
module qspi_sync_edge (
    input  logic clk,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Left unreset so that a reset can never fabricate an edge; the chain
    // settles to the pin level within three clocks.
    always_ff @(posedge clk) begin
        meta_reg <= din;
        sync_reg <= meta_reg;
        prev_reg <= sync_reg;
    end

    assign level = sync_reg;
    assign rise  = sync_reg & ~prev_reg;
    assign fall  = ~sync_reg & prev_reg;

endmodule

// File: rtl/qspi_psram_resp.sv
// Quad-SPI PSRAM responder: oversamples sck/ce_n on clk and serves 0xEB quad
// read / 0x38 quad write from an internal byte RAM. Option: QSPI_RESP_PAGE_WRAP_EN.
module qspi_psram_resp
    import qspi_resp_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int LATENCY   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] sio_i,
    output logic [3:0] sio_o,
    output logic       sio_oe,
    output logic       busy,
    output logic       cmd_err
);

    localparam int AW    = $clog2(MEM_BYTES);
    localparam int LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

`ifdef QSPI_RESP_PAGE_WRAP_EN
    localparam logic [AW-1:0] WRAP_MASK = (AW > 10) ? AW'(1023) : {AW{1'b1}};
`else
    localparam logic [AW-1:0] WRAP_MASK = {AW{1'b1}};
`endif

    // Bits outside WRAP_MASK are held, bits inside it count and wrap.
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (a & ~WRAP_MASK) | ((a + 1'b1) & WRAP_MASK);
    endfunction

    logic sck_level, sck_rise, sck_fall;
    logic ce_level, ce_rise, ce_fall;

    qspi_sync_edge u_sck_sync (
        .clk   (clk),
        .din   (sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    qspi_sync_edge u_ce_sync (
        .clk   (clk),
        .din   (ce_n),
        .level (ce_level),
        .rise  (ce_rise),
        .fall  (ce_fall)
    );

    // Data takes the same two-flop delay as sck so a synced rise samples
    // the nibble that was on the pins when sck actually rose.
    logic [3:0] sio_meta_reg;
    logic [3:0] sio_sync_reg;

    always_ff @(posedge clk) begin
        sio_meta_reg <= sio_i;
        sio_sync_reg <= sio_meta_reg;
    end

    state_t           state_reg, state_next;
    logic [2:0]       nib_cnt_reg;
    logic [19:0]      shift_reg;
    logic             is_write_reg;
    logic             phase_reg;
    logic [3:0]       wr_hi_reg;
    logic [LAT_W-1:0] lat_cnt_reg;
    logic [AW-1:0]    addr_reg, addr_next, mem_addr;
    logic [7:0]       rd_data_reg;
    logic [7:0]       mem [MEM_BYTES];
    logic [3:0]       sio_o_reg, sio_o_next;
    logic             sio_oe_reg, sio_oe_next;
    logic             cmd_err_reg, cmd_err_next;

    logic        ce_active, rise, fall;
    logic [7:0]  cmd_byte;
    logic [23:0] addr_full;
    logic        cmd_ok, last_cmd, last_addr, lat_done;
    logic        rd_start, rd_step, wr_step, mem_we;
    logic        unused_bits;

    // A deasserted ce_n masks any coincident sck edge.
    assign ce_active = ~ce_level;
    assign rise      = sck_rise & ce_active;
    assign fall      = sck_fall & ce_active;

    assign cmd_byte  = {shift_reg[3:0], sio_sync_reg};
    assign addr_full = {shift_reg, sio_sync_reg};
    assign cmd_ok    = (cmd_byte == CMD_QREAD) || (cmd_byte == CMD_QWRITE);
    assign last_cmd  = (state_reg == ST_CMD) && rise && (nib_cnt_reg == 3'd1);
    assign last_addr = (state_reg == ST_ADDR) && rise &&
                       (nib_cnt_reg == 3'(ADDR_NIBBLES - 1));
    assign lat_done  = (lat_cnt_reg == LAT_W'(LATENCY));
    assign rd_start  = (state_reg == ST_WAIT) && fall && lat_done;
    assign rd_step   = (state_reg == ST_RDATA) && fall;
    assign wr_step   = (state_reg == ST_WDATA) && rise;
    assign mem_we    = wr_step && phase_reg;

    assign unused_bits = ^{sck_level, ce_rise, addr_full};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (!ce_active) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  if (ce_fall)   state_next = ST_CMD;
                ST_CMD:   if (last_cmd)  state_next = cmd_ok ? ST_ADDR : ST_IGNORE;
                ST_ADDR:  if (last_addr) state_next = is_write_reg ? ST_WDATA : ST_WAIT;
                ST_WAIT:  if (rd_start)  state_next = ST_RDATA;
                default:  state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        sio_o_next   = sio_o_reg;
        sio_oe_next  = sio_oe_reg;
        cmd_err_next = 1'b0;
        if (!ce_active) begin
            sio_o_next  = 4'h0;
            sio_oe_next = 1'b0;
        end else if (rd_start) begin
            sio_oe_next = 1'b1;
            sio_o_next  = rd_data_reg[7:4];
        end else if (rd_step) begin
            sio_o_next  = phase_reg ? rd_data_reg[3:0] : rd_data_reg[7:4];
        end
        if (last_cmd && !cmd_ok) begin
            cmd_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sio_o_reg   <= 4'h0;
            sio_oe_reg  <= 1'b0;
            cmd_err_reg <= 1'b0;
        end else begin
            sio_o_reg   <= sio_o_next;
            sio_oe_reg  <= sio_oe_next;
            cmd_err_reg <= cmd_err_next;
        end
    end

    assign sio_o   = sio_o_reg;
    assign sio_oe  = sio_oe_reg;
    assign cmd_err = cmd_err_reg;
    assign busy    = (state_reg != ST_IDLE);

    // phase_reg set means the low nibble of the current byte comes next.
    always_comb begin
        addr_next = addr_reg;
        if (last_addr) begin
            addr_next = addr_full[AW-1:0];
        end else if ((rd_step || wr_step) && phase_reg) begin
            addr_next = addr_inc(addr_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nib_cnt_reg  <= 3'd0;
            shift_reg    <= 20'h0;
            is_write_reg <= 1'b0;
            phase_reg    <= 1'b0;
            wr_hi_reg    <= 4'h0;
            lat_cnt_reg  <= '0;
            addr_reg     <= '0;
        end else begin
            addr_reg <= addr_next;
            if (state_reg == ST_IDLE) begin
                nib_cnt_reg <= 3'd0;
            end else if (rise && (state_reg == ST_CMD || state_reg == ST_ADDR)) begin
                nib_cnt_reg <= last_cmd ? 3'd0 : nib_cnt_reg + 3'd1;
                shift_reg   <= addr_full[19:0];
            end
            if (last_cmd) begin
                is_write_reg <= (cmd_byte == CMD_QWRITE);
            end
            if (state_reg != ST_WAIT) begin
                lat_cnt_reg <= '0;
            end else if (rise && !lat_done) begin
                lat_cnt_reg <= lat_cnt_reg + 1'b1;
            end
            if (state_reg == ST_IDLE || state_reg == ST_ADDR) begin
                phase_reg <= 1'b0;
            end else if (rd_start) begin
                phase_reg <= 1'b1;
            end else if (rd_step || wr_step) begin
                phase_reg <= ~phase_reg;
            end
            if (wr_step && !phase_reg) begin
                wr_hi_reg <= sio_sync_reg;
            end
        end
    end

    // Single port: the write address is the current byte; otherwise the port
    // tracks addr_next so the read data is ready one clk after any move.
    assign mem_addr = mem_we ? addr_reg : addr_next;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= {wr_hi_reg, sio_sync_reg};
        end
        rd_data_reg <= mem[mem_addr];
    end

endmodule
